ps2_rx: RTL and testbench

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_rx.sv | 176 +++++++++++++++++
 tb/tb_ps2_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host serial receiver.
//
// Both line inputs pass through 2-flop synchronizers. ps2_clk is then
// glitch-filtered, and the frame (start, 8 data LSB first, odd parity, stop)
// is shifted in on falling edges of the filtered clock.
//
// Parameters:
//   FILTER_LEN  - cycles the synchronized ps2_clk must hold a new level
//   TIMEOUT_CYC - idle-line watchdog limit in clk cycles
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   ps2_clk   - PS/2 clock line (async, idle high)
//   ps2_dat   - PS/2 data line (async, idle high)
//   data      - last correctly received byte
//   valid     - one-cycle pulse, data updated and good
//   frame_err - one-cycle pulse, frame rejected
//   busy      - high while a frame is in progress
// Configuration:
//   PS2_RX_TIMEOUT_EN - when defined, a watchdog aborts a stalled frame in SHIFT.
module ps2_rx #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 2400
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam int unsigned FCW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  // Synchronizers
  logic r_clk_meta, r_clk_sync;
  logic r_dat_meta, r_dat_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_dat;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Glitch filter: r_filt_cnt counts consecutive cycles the synchronized
  // clock has disagreed with the filtered one; the flip happens on the
  // FILTER_LEN-th such cycle.
  logic           r_clk_filt;
  logic [FCW-1:0] r_filt_cnt;
  logic           w_differ;
  logic           w_flip;
  logic           w_fall;

  assign w_differ = (r_clk_sync != r_clk_filt);
  assign w_flip   = w_differ && (r_filt_cnt == FCW'(FILTER_LEN - 1));
  // Falling edge of the filtered clock: the cycle in which it goes 1 -> 0.
  assign w_fall   = w_flip && r_clk_filt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_flip) begin
      r_clk_filt <= r_clk_sync;
      r_filt_cnt <= '0;
    end else if (w_differ) begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end else begin
      r_filt_cnt <= '0;
    end
  end

  // Frame FSM
  logic [1:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [9:0] r_shift;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_err;
  logic       w_good;

  // After 10 shifts: [7:0] data, [8] parity, [9] stop.
  assign w_good = (^r_shift[8:0]) && r_shift[9];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] r_wd;
  logic           w_wd_hit;
  assign w_wd_hit = (r_wd == WDW'(TIMEOUT_CYC - 1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      r_wd      <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
`ifdef PS2_RX_TIMEOUT_EN
          r_wd      <= '0;
`endif
          // A sampled 1 here is a false start and is simply ignored.
          if (w_fall && !r_dat_sync) begin
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_fall) begin
            r_shift <= {r_dat_sync, r_shift[9:1]};
`ifdef PS2_RX_TIMEOUT_EN
            r_wd    <= '0;
`endif
            if (r_bit_cnt == 4'd9) begin
              r_state   <= ST_CHECK;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
`ifdef PS2_RX_TIMEOUT_EN
          else if (w_wd_hit) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_wd      <= '0;
            r_err     <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
`endif
        end
        ST_CHECK: begin
          if (w_good) begin
            r_data  <= r_shift[7:0];
            r_valid <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_err;
  assign busy      = (r_state == ST_SHIFT) || (r_state == ST_CHECK);

endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
module tb_ps2_rx;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 2400;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  ps2_rx #(
    .FILTER_LEN (FL),
    .TIMEOUT_CYC(TO)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // ~12 MHz
  always #42 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
    logic       lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  model_data = 8'h00;
  logic [7:0]  prev_data = 8'h00;
  int unsigned t_stop = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a frame; optional low glitch in the high phase of
  // bit glitch_bit.
  task automatic send_bits(input logic [7:0] d, input logic par, input logic stop,
                           input int half, input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      if (i == glitch_bit) begin
        wait_cyc(half / 4);
        ps2_clk = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk = 1'b1;
        wait_cyc(half - half / 4 - (FL - 1));
      end else begin
        wait_cyc(half);
      end
      ps2_clk = 1'b0;
      if (i == 10) t_stop = cyc;
      wait_cyc(half);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic finish_frame(input string tag);
    wait_cyc(30);
    check_eq({tag, "_pending"}, sb.size(), 0);
    check_eq({tag, "_busy_idle"}, busy, 1'b0);
  endtask

  task automatic send_good(input logic [7:0] d, input int half, input int glitch_bit);
    model_data = d;
    sb.push_back('{err: 1'b0, d: d, lat: 1'b1});
    send_bits(d, ~^d, 1'b1, half, 11, glitch_bit);
    finish_frame("good");
    check_eq("good_data_hold", data, d);
  endtask

  task automatic send_bad(input logic [7:0] d, input logic par, input logic stop);
    sb.push_back('{err: 1'b1, d: model_data, lat: 1'b1});
    send_bits(d, par, stop, 60, 11, -1);
    finish_frame("bad");
  endtask

  // Output monitor / scoreboard
  exp_t e;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (valid || frame_err) begin
        check_eq("pulse_exclusive", valid & frame_err, 1'b0);
        if (sb.size() == 0) begin
          check_eq("spurious_pulse", {valid, frame_err}, 2'b00);
        end else begin
          e = sb.pop_front();
          check_eq("pulse_kind", frame_err, e.err);
          check_eq("pulse_data", data, e.d);
          if (e.lat) check_eq("latency", (cyc - t_stop) <= (2 + FL + 2), 1'b1);
        end
      end
      if (data !== prev_data && !valid) check_eq("data_stable", data, prev_data);
    end
    prev_data = data;
  end

  initial begin
    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(5);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_err", frame_err, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    wait_cyc(5);

    // 0xA5 at 10 kHz then 16.7 kHz
    send_good(8'hA5, 600, -1);
    send_good(8'hA5, 360, -1);

    // Wrong parity, then bad stop bit, then a good frame
    send_bad(8'h3C, 1'b0, 1'b1);
    send_bad(8'h00, 1'b1, 1'b0);
    send_good(8'h81, 60, -1);

    // Glitch while idle, then glitch during SHIFT
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check_eq("idle_glitch_busy", busy, 1'b0);
    send_good(8'h6B, 60, 4);

    // Reset in the middle of a frame; remaining bits are all 1
    send_bits(8'hC3, 1'b1, 1'b1, 60, 7, -1);
    wait_cyc(30);
    check_eq("mid_frame_busy", busy, 1'b1);
    reset_n = 1'b0;
    wait_cyc(3);
    check_eq("midrst_data", data, 8'h00);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_valid", valid, 1'b0);
    check_eq("midrst_err", frame_err, 1'b0);
    model_data = 8'h00;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ps2_dat = 1'b1;
      wait_cyc(60);
      ps2_clk = 1'b0;
      wait_cyc(60);
      ps2_clk = 1'b1;
    end
    finish_frame("tail");
    send_good(8'hFF, 60, -1);

`ifdef PS2_RX_TIMEOUT_EN
    sb.push_back('{err: 1'b1, d: model_data, lat: 1'b0});
    send_bits(8'h77, 1'b0, 1'b1, 60, 5, -1);
    wait_cyc(2500);
    check_eq("timeout_pending", sb.size(), 0);
    check_eq("timeout_busy", busy, 1'b0);
    send_good(8'h5A, 60, -1);
`endif

    wait_cyc(10);
    check_eq("final_pending", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
